spi_slave: RTL
==============

Name: spi_slave

Overview:
SPI Mode 0 (CPOL=0, CPHA=0) responder, 8-bit frames, MSB first. It is the far-end peer of the team's spi_master.
- Oversamples SCK, MOSI and CS_N on the system clock.
- Delivers each received byte on a one-cycle valid pulse.
- Shifts out transmit bytes supplied through a valid/ready holding register.
- Supports back-to-back bytes while CS_N stays low.

Parameters:
TX_DEFAULT, 8'hFF, byte shifted out when no transmit data is queued at byte start.
WATCHDOG_LIMIT, 100000, clk cycles without an SCK edge while selected before abort (used only with SPIS_WATCHDOG_EN).

Ports:
clk  input  1  system clock; all logic on posedge.
rst_n  input  1  asynchronous active-low reset.
tx_data_i  input  8  byte to transmit.
tx_valid_i  input  1  tx_data_i valid.
tx_ready_o  output  1  holding register empty; transfer occurs when tx_valid_i & tx_ready_o.
rx_data_o  output  8  last complete received byte; held until next complete byte.
rx_valid_o  output  1  one-cycle pulse when rx_data_o updates.
underrun_o  output  1  one-cycle pulse when a byte starts with the holding register empty.
error_o  output  1  one-cycle pulse on aborted frame (CS_N rise mid-byte, or watchdog).
busy_o  output  1  high while selected (state ACTIVE).
sck_i  input  1  SPI clock from master, asynchronous.
mosi_i  input  1  master-out data, asynchronous.
cs_n_i  input  1  chip select, active low, asynchronous.
miso_o  output  1  slave-out data.
miso_oe_o  output  1  MISO drive enable; high only while selected.

Behaviour:
- Reset values:
  - All outputs 0, except tx_ready_o=1.
  - Synchronizers: sck=0, mosi=0, cs_n=1.
  - Shift registers, holding register and bit counter 0; state IDLE.
- Input synchronization:
  - sck_i, mosi_i and cs_n_i each pass through a 2-FF synchronizer.
  - Edges are detected by comparing the synchronized value with a third registered copy.
- Timing requirement: f_SCK <= f_clk/8, and CS_N fall to first SCK rise >= 4 clk. spi_master with CLK_DIV>=4 complies.
- States: IDLE, ACTIVE, WAIT_CS. WAIT_CS is reachable only with the watchdog.
- IDLE:
  - miso_oe_o=0, busy_o=0.
  - On synchronized CS_N fall: byte-start load, then go to ACTIVE.
- Byte-start load:
  - If the holding register is full: tx_shift <= holding, and the holding register is marked empty (tx_ready_o=1 next cycle).
  - If the holding register is empty: tx_shift <= TX_DEFAULT, and underrun_o pulses.
  - In both cases: miso_o <= new byte bit 7, bit_cnt <= 0.
- ACTIVE:
  - miso_oe_o=1, busy_o=1.
  - SCK rise: rx_shift <= {rx_shift[6:0], mosi_sync}; bit_cnt++.
  - On the 8th rise (bit_cnt 7->8), in the next cycle: rx_data_o <= assembled byte, rx_valid_o=1 for one cycle.
  - SCK fall with bit_cnt<8: tx_shift shifts left; miso_o <= next bit.
  - SCK fall with bit_cnt==8: byte-start load (back-to-back byte, same underrun rule).
- CS_N rise in ACTIVE:
  - Always go to IDLE; miso_oe_o drops the next cycle.
  - bit_cnt==0 or 8: clean end, no error.
  - Otherwise: partial rx bits discarded, no rx_valid_o, error_o pulses.
  - An unsent tx_shift byte is discarded; the holding register is unaffected.
- Holding register:
  - Written on tx_valid_i & tx_ready_o in any state.
  - Write and byte-start load in the same cycle with the register empty: the load uses TX_DEFAULT and underrun_o pulses; the new data stays queued for the next byte.
- SCK edges while CS_N is high are ignored.
- rst_n assertion mid-frame: immediate return to reset values; no pulses are generated.

Optional Feature:
Macro: SPIS_WATCHDOG_EN.
- Defined:
  - A 32-bit counter clears in IDLE and on every synchronized SCK edge, and increments in ACTIVE.
  - When it exceeds WATCHDOG_LIMIT: error_o pulses, miso_oe_o drops, partial byte discarded, state goes to WAIT_CS.
  - WAIT_CS ignores SCK and returns to IDLE on synchronized CS_N high.
- Undefined: no counter and no WAIT_CS; ACTIVE persists indefinitely while CS_N stays low.

Test Plan:
1. Queue 8'hA5, then spi_master (CLK_DIV=4) sends 8'h3C -> master receives 8'hA5; rx_data_o=8'h3C with one rx_valid_o pulse; tx_ready_o=1 after CS_N fall; no underrun_o or error_o.
2. No queued data, master sends 8'h81 -> master receives 8'hFF; underrun_o pulses once at CS_N fall; rx_data_o=8'h81.
3. CS_N held low for 3 bytes 8'h01, 8'h02, 8'h03, with 8'h11/8'h22/8'h33 queued just-in-time on tx_ready_o -> three rx_valid_o pulses with 01, 02, 03; master receives 11, 22, 33.
4. CS_N rises after 5 SCK rises -> error_o pulses once; no rx_valid_o; rx_data_o holds its previous value; next full frame is received correctly.
5. rst_n low for 2 cycles mid-byte -> all outputs at reset values asynchronously; a following frame of 8'h5A is received cleanly.
6. With SPIS_WATCHDOG_EN and WATCHDOG_LIMIT=50: CS_N low with no SCK for 60 cycles -> error_o pulses; miso_oe_o=0; SCK toggles are ignored until CS_N goes high; the next frame is normal.

Source files
------------

// File: rtl/spi_slave.sv
// SPI Mode 0 responder: 8-bit frames, MSB first, oversampled on clk.
// Received bytes come out with a one-cycle rx_valid_o pulse. Transmit bytes
// are queued through a single valid/ready holding register.
// Optional macro SPIS_WATCHDOG_EN adds an SCK-inactivity watchdog and the
// WAIT_CS state.
module spi_slave #(
    parameter logic [7:0]  TX_DEFAULT     = 8'hFF,
    parameter int unsigned WATCHDOG_LIMIT = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    output logic       underrun_o,
    output logic       error_o,
    output logic       busy_o,
    input  logic       sck_i,
    input  logic       mosi_i,
    input  logic       cs_n_i,
    output logic       miso_o,
    output logic       miso_oe_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACTIVE  = 2'd1,
        WAIT_CS = 2'd2
    } state_t;

    // Synchronizer chains: meta -> sync, plus a previous copy for edge detection
    logic sck_meta_q, sck_sync_q, sck_prev_q;
    logic mosi_meta_q, mosi_sync_q;
    logic cs_meta_q, cs_sync_q, cs_prev_q;

    logic sck_rise_s, sck_fall_s, cs_fall_s, cs_rise_s;

    state_t     state_q, state_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic [7:0] rx_shift_q, rx_shift_d;
    logic [7:0] hold_q, hold_d;
    logic       tx_ready_q, tx_ready_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       underrun_q, underrun_d;
    logic       error_q, error_d;
    logic       miso_q, miso_d;
    logic       miso_oe_q, miso_oe_d;
    logic       busy_q, busy_d;
    logic       load_s, wr_s;
`ifdef SPIS_WATCHDOG_EN
    logic [31:0] wd_cnt_q, wd_cnt_d;
`endif

    // Bring the asynchronous SPI pins into the clk domain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_meta_q  <= 1'b0;
            sck_sync_q  <= 1'b0;
            sck_prev_q  <= 1'b0;
            mosi_meta_q <= 1'b0;
            mosi_sync_q <= 1'b0;
            cs_meta_q   <= 1'b1;
            cs_sync_q   <= 1'b1;
            cs_prev_q   <= 1'b1;
        end else begin
            sck_meta_q  <= sck_i;
            sck_sync_q  <= sck_meta_q;
            sck_prev_q  <= sck_sync_q;
            mosi_meta_q <= mosi_i;
            mosi_sync_q <= mosi_meta_q;
            cs_meta_q   <= cs_n_i;
            cs_sync_q   <= cs_meta_q;
            cs_prev_q   <= cs_sync_q;
        end
    end

    assign sck_rise_s = sck_sync_q & ~sck_prev_q;
    assign sck_fall_s = ~sck_sync_q & sck_prev_q;
    assign cs_fall_s  = ~cs_sync_q & cs_prev_q;
    assign cs_rise_s  = cs_sync_q & ~cs_prev_q;
    assign wr_s       = tx_valid_i & tx_ready_q;

    // Next-state, shift, holding-register and pulse logic
    always_comb begin
        state_d    = state_q;
        tx_shift_d = tx_shift_q;
        rx_shift_d = rx_shift_q;
        hold_d     = hold_q;
        tx_ready_d = tx_ready_q;
        bit_cnt_d  = bit_cnt_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        underrun_d = 1'b0;
        error_d    = 1'b0;
        miso_d     = miso_q;
        load_s     = 1'b0;
`ifdef SPIS_WATCHDOG_EN
        if ((state_q != ACTIVE) || sck_rise_s || sck_fall_s) begin
            wd_cnt_d = 32'd0;
        end else begin
            wd_cnt_d = wd_cnt_q + 32'd1;
        end
`endif

        case (state_q)
            IDLE: begin
                if (cs_fall_s) begin
                    load_s  = 1'b1;
                    state_d = ACTIVE;
                end else begin
                    state_d = IDLE;
                end
            end
            ACTIVE: begin
                if (cs_rise_s) begin
                    // A deselect between bytes is a clean end; mid-byte is an abort
                    state_d   = IDLE;
                    error_d   = (bit_cnt_q != 4'd0) && (bit_cnt_q != 4'd8);
                    bit_cnt_d = 4'd0;
`ifdef SPIS_WATCHDOG_EN
                end else if (wd_cnt_q > WATCHDOG_LIMIT) begin
                    state_d   = WAIT_CS;
                    error_d   = 1'b1;
                    bit_cnt_d = 4'd0;
`endif
                end else if (sck_rise_s && (bit_cnt_q < 4'd8)) begin
                    rx_shift_d = {rx_shift_q[6:0], mosi_sync_q};
                    bit_cnt_d  = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd7) begin
                        rx_data_d  = {rx_shift_q[6:0], mosi_sync_q};
                        rx_valid_d = 1'b1;
                    end else begin
                        rx_valid_d = 1'b0;
                    end
                end else if (sck_fall_s) begin
                    if (bit_cnt_q == 4'd8) begin
                        load_s = 1'b1;
                    end else begin
                        tx_shift_d = {tx_shift_q[6:0], 1'b0};
                        miso_d     = tx_shift_q[6];
                    end
                end else begin
                    state_d = ACTIVE;
                end
            end
            WAIT_CS: begin
                if (cs_sync_q) begin
                    state_d = IDLE;
                end else begin
                    state_d = WAIT_CS;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Byte-start load: take the queued byte, or fall back to TX_DEFAULT
        if (load_s) begin
            bit_cnt_d = 4'd0;
            if (!tx_ready_q) begin
                tx_shift_d = hold_q;
                miso_d     = hold_q[7];
                tx_ready_d = 1'b1;
            end else begin
                tx_shift_d = TX_DEFAULT;
                miso_d     = TX_DEFAULT[7];
                underrun_d = 1'b1;
            end
        end else begin
            bit_cnt_d = bit_cnt_d;
        end

        // A write that races an empty-register load stays queued for the next byte
        if (wr_s) begin
            hold_d     = tx_data_i;
            tx_ready_d = 1'b0;
        end else begin
            hold_d = hold_d;
        end

        miso_oe_d = (state_d == ACTIVE);
        busy_d    = (state_d == ACTIVE);
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            tx_shift_q <= 8'h00;
            rx_shift_q <= 8'h00;
            hold_q     <= 8'h00;
            tx_ready_q <= 1'b1;
            bit_cnt_q  <= 4'd0;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            underrun_q <= 1'b0;
            error_q    <= 1'b0;
            miso_q     <= 1'b0;
            miso_oe_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_shift_q <= tx_shift_d;
            rx_shift_q <= rx_shift_d;
            hold_q     <= hold_d;
            tx_ready_q <= tx_ready_d;
            bit_cnt_q  <= bit_cnt_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            underrun_q <= underrun_d;
            error_q    <= error_d;
            miso_q     <= miso_d;
            miso_oe_q  <= miso_oe_d;
            busy_q     <= busy_d;
        end
    end

`ifdef SPIS_WATCHDOG_EN
    // SCK inactivity counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt_q <= 32'd0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
        end
    end
`endif

    assign tx_ready_o = tx_ready_q;
    assign rx_data_o  = rx_data_q;
    assign rx_valid_o = rx_valid_q;
    assign underrun_o = underrun_q;
    assign error_o    = error_q;
    assign busy_o     = busy_q;
    assign miso_o     = miso_q;
    assign miso_oe_o  = miso_oe_q;

endmodule
